// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, emulator FSM states and the
// code-to-matrix-position lookup used by the emulator and scanner benches.
package keypad_pkg;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_PRESS,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] c;
  } key_pos_t;

  function automatic key_pos_t key_to_pos(input logic [3:0] code);
    key_pos_t p;
    case (code)
      4'h1:     p = {2'd0, 2'd0};
      4'h2:     p = {2'd0, 2'd1};
      4'h3:     p = {2'd0, 2'd2};
      KEY_A:    p = {2'd0, 2'd3};
      4'h4:     p = {2'd1, 2'd0};
      4'h5:     p = {2'd1, 2'd1};
      4'h6:     p = {2'd1, 2'd2};
      KEY_B:    p = {2'd1, 2'd3};
      4'h7:     p = {2'd2, 2'd0};
      4'h8:     p = {2'd2, 2'd1};
      4'h9:     p = {2'd2, 2'd2};
      KEY_C:    p = {2'd2, 2'd3};
      KEY_STAR: p = {2'd3, 2'd0};
      4'h0:     p = {2'd3, 2'd1};
      KEY_HASH: p = {2'd3, 2'd2};
      default:  p = {2'd3, 2'd3};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/keypad_scan_monitor.sv
// Registers the scanner column drive and flags the first cycle of each scan
// (column 0 newly asserted).
module keypad_scan_monitor (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic       scan_start
);

  logic [3:0] col_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) col_prev <= 4'hF;
    else      col_prev <= col;
  end

  assign scan_start = (col == 4'b1110) && (col_prev != 4'b1110);

endmodule

// File: rtl/keypad_emulator.sv
// Drive side of a 4x4 matrix keypad: presses each accepted key for HOLD_SCANS
// full scans, then releases it for GAP_SCANS. KEYPAD_EMU_TIMEOUT_EN adds a scan-activity timeout.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_SCANS     = 2,
  parameter int GAP_SCANS      = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CNT_W = $clog2(((HOLD_SCANS > GAP_SCANS) ? HOLD_SCANS : GAP_SCANS) + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_SCANS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_SCANS - 1);

  if (HOLD_SCANS < 2 || HOLD_SCANS > 255 || GAP_SCANS < 1 || GAP_SCANS > 255 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("keypad_emulator: parameter out of range");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       r_sel, c_sel;
  logic             scan_start;
  logic             accept;
  logic             drive;
  logic             timeout;

  keypad_scan_monitor u_mon (
    .clk        (clk),
    .rst        (rst),
    .col        (col),
    .scan_start (scan_start)
  );

`ifdef KEYPAD_EMU_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] tcnt;

  // Held at zero in IDLE, so entry to ARM always starts a fresh count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               tcnt <= '0;
    else if (state == ST_IDLE || scan_start) tcnt <= '0;
    else                                    tcnt <= tcnt + 1'b1;
  end

  assign timeout = (state != ST_IDLE) && (tcnt == TO_W'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    drive     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (key_valid) begin
          accept    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_ARM;
        end
      end
      ST_ARM: begin
        if (scan_start) begin
          drive     = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_PRESS;
        end
      end
      ST_PRESS: begin
        // Release on the scan start that would begin scan HOLD_SCANS+1.
        if (scan_start && cnt == HOLD_LAST) begin
          cnt_nxt   = '0;
          state_nxt = ST_GAP;
        end else begin
          drive = 1'b1;
          if (scan_start) cnt_nxt = cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (scan_start) begin
          if (cnt == GAP_LAST) state_nxt = ST_IDLE;
          else                 cnt_nxt   = cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (timeout) begin
      drive     = 1'b0;
      cnt_nxt   = '0;
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      r_sel <= 2'd0;
      c_sel <= 2'd0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) {r_sel, c_sel} <= key_to_pos(key_code);
      done  <= (state == ST_GAP) && scan_start && (cnt == GAP_LAST) && !timeout;
      err   <= timeout;
    end
  end

  // Combinational from col so the scanner sees the row in the cycle it drives the column.
  always_comb begin
    row = 4'hF;
    if (drive && !col[c_sel]) row[r_sel] = 1'b0;
  end

  assign key_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator acting as the scanner: rotates columns and
// decodes the returned rows against the keypad code map.
module tb_keypad_emulator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] col = 4'hF;
  logic [3:0] row;
  logic [3:0] key_code = 4'h0;
  logic       key_valid = 1'b0;
  logic       key_ready, busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  keypad_emulator #(
    .HOLD_SCANS     (2),
    .GAP_SCANS      (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Key code found at matrix position row*4+col.
  logic [3:0] code_at  [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
  logic [3:0] step_col [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] obs_row  [40][4];
  logic       obs_done [40][4];
  int         obs_key  [40];
  logic [3:0] codes    [4];

  task automatic run_scans(input int nscans, input int nkeys);
    int   idx;
    logic take;
    idx       = 0;
    key_code  = codes[0];
    key_valid = (nkeys > 0);
    #1 take = key_valid && key_ready;
    for (int s = 0; s < nscans; s++) begin
      obs_key[s] = -1;
      for (int st = 0; st < 4; st++) begin
        @(posedge clk); #1;
        if (take) begin
          idx++;
          if (idx < nkeys) key_code = codes[idx];
          else             key_valid = 1'b0;
        end
        col = step_col[st];
        @(negedge clk);
        obs_row[s][st]  = row;
        obs_done[s][st] = done;
        for (int r = 0; r < 4; r++) if (!row[r]) obs_key[s] = int'(code_at[r*4+st]);
        take = key_valid && key_ready;
      end
    end
    @(posedge clk); #1 col = 4'hF;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; key_valid = 1'b0; col = 4'hF;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic accept_key(input logic [3:0] code);
    @(posedge clk); #1;
    key_code = code; key_valid = 1'b1; col = 4'hF;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (row !== 4'hF)      begin n_bad++; $display("FAIL reset_row: got %h want f", row); end
    n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", key_ready); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL reset_pulses: got done=%b err=%b want 0 0", done, err);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_idle_scan();
    run_scans(2, 0);
    for (int s = 0; s < 2; s++)
      for (int st = 0; st < 4; st++) begin
        n_cmp++;
        if (obs_row[s][st] !== 4'hF) begin
          n_bad++; $display("FAIL idle_row s%0d c%0d: got %b want 1111", s, st, obs_row[s][st]);
        end
      end
    n_cmp++; if (key_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL idle_status: got ready=%b busy=%b want 1 0", key_ready, busy);
    end
  endtask

  task automatic test_single_key();
    logic [3:0] exp_row;
    logic       exp_done;
    codes[0] = 4'h5;
    run_scans(5, 1);
    for (int s = 0; s < 5; s++)
      for (int st = 0; st < 4; st++) begin
        exp_row  = (s < 2 && st == 1) ? 4'b1101 : 4'b1111;
        exp_done = (s == 4 && st == 1);
        n_cmp++;
        if (obs_row[s][st] !== exp_row) begin
          n_bad++; $display("FAIL key5_row s%0d c%0d: got %b want %b", s, st, obs_row[s][st], exp_row);
        end
        n_cmp++;
        if (obs_done[s][st] !== exp_done) begin
          n_bad++; $display("FAIL key5_done s%0d c%0d: got %b want %b", s, st, obs_done[s][st], exp_done);
        end
      end
  endtask

  task automatic test_back_to_back();
    int   exp_key;
    logic exp_done;
    codes = '{4'h1, 4'h2, 4'hF, 4'hD};
    run_scans(20, 4);
    for (int s = 0; s < 20; s++) begin
      exp_key = (s % 5 < 2) ? int'(codes[s/5]) : -1;
      n_cmp++;
      if (obs_key[s] !== exp_key) begin
        n_bad++; $display("FAIL b2b_key scan%0d: got %0d want %0d", s, obs_key[s], exp_key);
      end
      for (int st = 0; st < 4; st++) begin
        exp_done = (s % 5 == 4 && st == 1);
        n_cmp++;
        if (obs_done[s][st] !== exp_done) begin
          n_bad++; $display("FAIL b2b_done s%0d c%0d: got %b want %b", s, st, obs_done[s][st], exp_done);
        end
      end
    end
  endtask

  task automatic test_start_with_valid();
    @(posedge clk); #1 col = 4'b0111;
    @(posedge clk); #1 col = 4'b1110; key_code = 4'h5; key_valid = 1'b1;
    @(posedge clk); #1 col = 4'b1101; key_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (row !== 4'hF || busy !== 1'b1) begin
      n_bad++; $display("FAIL same_cycle_arm: got row=%b busy=%b want 1111 1", row, busy);
    end
    for (int st = 2; st < 4; st++) begin @(posedge clk); #1 col = step_col[st]; end
    @(posedge clk); #1 col = 4'b1110;
    @(posedge clk); #1 col = 4'b1101;
    @(negedge clk);
    n_cmp++; if (row !== 4'b1101) begin
      n_bad++; $display("FAIL same_cycle_press: got %b want 1101", row);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_press();
    accept_key(4'h0);
    col = 4'b1110;
    @(posedge clk); #1 col = 4'b1101;
    @(negedge clk);
    n_cmp++; if (row !== 4'b0111) begin
      n_bad++; $display("FAIL key0_press: got %b want 0111", row);
    end
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (row !== 4'hF) begin
      n_bad++; $display("FAIL async_release: got %b want 1111", row);
    end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 col = step_col[i % 4];
      @(negedge clk);
      n_cmp++; if (key_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        n_bad++; $display("FAIL post_reset c%0d: got ready=%b busy=%b done=%b want 1 0 0",
                          i, key_ready, busy, done);
      end
    end
    @(posedge clk); #1 col = 4'hF;
  endtask

  task automatic test_illegal_col();
    accept_key(4'h4);
    col = 4'b1110;
    @(negedge clk);
    n_cmp++; if (row !== 4'b1101) begin
      n_bad++; $display("FAIL key4_col0: got %b want 1101", row);
    end
    @(posedge clk); #1 col = 4'b1100;
    @(negedge clk);
    n_cmp++; if (row !== 4'b1101) begin
      n_bad++; $display("FAIL multi_col: got %b want 1101", row);
    end
    @(posedge clk); #1 col = 4'b1011;
    @(negedge clk);
    n_cmp++; if (row !== 4'hF) begin
      n_bad++; $display("FAIL other_col: got %b want 1111", row);
    end
    do_reset();
  endtask

  task automatic test_timeout();
    int n_err;
    int n_row_bad;
    n_err = 0;
    n_row_bad = 0;
    accept_key(4'h7);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (err === 1'b1) n_err++;
      if (row !== 4'hF) n_row_bad++;
    end
    n_cmp++; if (n_row_bad != 0) begin
      n_bad++; $display("FAIL timeout_rows: got %0d driven cycles want 0", n_row_bad);
    end
`ifdef KEYPAD_EMU_TIMEOUT_EN
    n_cmp++; if (n_err != 1) begin
      n_bad++; $display("FAIL timeout_err: got %0d pulses want 1", n_err);
    end
    n_cmp++; if (busy !== 1'b0) begin
      n_bad++; $display("FAIL timeout_busy: got %b want 0", busy);
    end
`else
    n_cmp++; if (n_err != 0) begin
      n_bad++; $display("FAIL timeout_err: got %0d pulses want 0", n_err);
    end
    n_cmp++; if (busy !== 1'b1) begin
      n_bad++; $display("FAIL timeout_busy: got %b want 1", busy);
    end
`endif
    do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_idle_scan();
    test_single_key();
    test_back_to_back();
    test_start_with_valid();
    test_reset_mid_press();
    test_illegal_col();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Keypad emulator: the drive side of the 4x4 matrix keypad interface. It accepts 4-bit key codes over a valid/ready handshake and "presses" each key by pulling the matching row line low while the external scanner drives that key's column low. Each key is held for a fixed number of complete scan cycles, then released for a fixed gap. Used in benches and in self-test builds in place of a physical keypad, closed-loop with the team's 4x4 scanner (keypad4x4a).

## Interface
- HOLD_SCANS, 2: complete scan cycles a key is held pressed; legal range 2..255.
- GAP_SCANS, 2: complete scan cycles of release after each press; legal range 1..255.
- TIMEOUT_CYCLES, 1024: clocks without a scan start before the current key is aborted; used only with the configuration macro.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- col  in  4  column drive from the scanner, active-low; one bit low per scan step.
- row  out  4  row lines to the scanner, active-low (1 = released).
- key_code  in  4  key to press; same code map as the scanner: 0x0..0x9 digits, A=10, B=11, C=12, D=13, *=14, #=15.
- key_valid  in  1  key_code valid.
- key_ready  out  1  emulator can accept a key.
- busy  out  1  key in progress (ARM, PRESS or GAP).
- done  out  1  one-cycle pulse: a key has finished, including its gap.
- err  out  1  one-cycle pulse: a key was aborted by timeout.

## Operation
- Code map (row, col): 1(0,0) 2(0,1) 3(0,2) A(0,3) 4(1,0) 5(1,1) 6(1,2) B(1,3) 7(2,0) 8(2,1) 9(2,2) C(2,3) *(3,0) 0(3,1) #(3,2) D(3,3).
- scan_start = (col == 4'b1110) && (col_prev != 4'b1110). col_prev is col registered, and resets to 4'b1111.
- FSM states: IDLE, ARM, PRESS, GAP.
  - IDLE: key_ready=1. On key_valid, latch key_code as (r_sel, c_sel), clear the scan counter, and go to ARM.
  - ARM: wait for scan_start. On scan_start, go to PRESS with cnt=0.
  - PRESS: on each scan_start, cnt++. On the scan_start with cnt==HOLD_SCANS-1, go to GAP with cnt=0.
  - GAP: on each scan_start, cnt++. On the scan_start with cnt==GAP_SCANS-1, go to IDLE.
- drive = (ARM && scan_start) || (PRESS && !(scan_start && cnt==HOLD_SCANS-1)).
  - Result: the key is pressed for exactly HOLD_SCANS complete scans, starting at column 0.
- row[r] = ~(drive && r==r_sel && col[c_sel]==0). This is combinational from col, so the scanner sees the row in the same cycle it drives the column.
- Illegal col patterns:
  - Multiple columns low: the row is driven only if the selected column bit is low.
  - col==4'b1111: all rows released.
- Counter width: clog2 of (max(HOLD_SCANS, GAP_SCANS) + 1).
- key_code need not be held stable after acceptance. key_valid while key_ready=0 is ignored and not queued.
- busy = state != IDLE.

## Timing
- Reset values:
  - state=IDLE; row=4'hF; key_ready=1; busy=0; done=0; err=0; cnt=0; col_prev=4'hF.
- Reset asserted mid-press releases all rows immediately (asynchronous).
- Acceptance to ARM: 1 clock.
- Press starts at the next scan_start after entering ARM.
  - If col already reads 1110 with col_prev != 1110 on the first ARM cycle, the press starts that cycle.
- done and err are registered. Each is high for exactly 1 cycle, in the cycle after the transition to IDLE.
  - key_ready is already 1 in that cycle, so back-to-back keys lose no cycles.
- A scan_start and key_valid in the same IDLE cycle: the key is accepted; the scan_start is not used for ARM.

## Configuration
- KEYPAD_EMU_TIMEOUT_EN:
  - Defined: a cycle counter runs in ARM, PRESS and GAP, and clears on every scan_start and on entry to ARM. When it reaches TIMEOUT_CYCLES, the FSM goes to IDLE, rows release in that cycle, err pulses, and done stays 0.
  - Undefined: no counter; err is tied to 0; the FSM waits indefinitely for scan activity.

## Structure
- Package keypad_pkg:
  - Key code constants (KEY_A..KEY_HASH).
  - FSM state enum.
  - Code-to-(row, col) lookup function, shared with the scanner benches.
- Sub-module keypad_scan_monitor: registers col and produces scan_start. Reused by the scanner test harnesses.

## Test plan
- Reset, then drive col=1110/1101/1011/0111 in rotation with no key -> row=4'hF constantly, key_ready=1, busy=0.
- Closed loop with the 4x4 scanner, push key 5 -> scanner buttons==16'h0020 for at least one full cycle, then 16'h0000. done pulses once, after 4 scans (HOLD_SCANS=2 plus GAP_SCANS=2).
- Push 1, 2, #, D back-to-back, with key_valid held and the code changed on each key_ready -> scanner shows bits 1, 2, 15, 13 in order, each separated by all-zero cycles. Four done pulses.
- Hold col=1111 after accepting key 7, with the macro defined and TIMEOUT_CYCLES=16 -> err pulses at cycle 17, busy drops, rows stay 4'hF. Without the macro: busy stays 1.
- Assert rst during PRESS for key 0 while col=1101 -> row[3] returns to 1 in the same cycle. After release: key_ready=1 and done is not pulsed.
- Drive col=1100 during PRESS of key 4 -> row=4'b1101. With col=1011: row=4'hF.
